// File: rtl/instr_fetch_ctrl_if.sv
// Signal bundle between the fetch sequencer, the instruction ROM,
// the decode stage and the later pipeline stages that steer fetch.
interface instr_fetch_ctrl_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, redirect_valid, redirect_pc, halt_req, resume, rom_instr,
    output rom_en, rom_addr, id_instr, id_pc, id_valid, fault, fault_addr, fetch_cnt
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, halt_req, resume, rom_instr,
    input  rom_en, rom_addr, id_instr, id_pc, id_valid, fault, fault_addr, fetch_cnt
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a combinational ROM and fills the
// IF/ID register, with stall, redirect, halt/resume and sticky fault handling.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_FAULT} state_t;

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [31:0] r_fetch_cnt;

  logic w_in_range;
  logic w_redir_ok;
  logic w_redir_bad;
  logic w_halt_now;

  assign w_in_range  = (r_pc < LIMIT);
  assign w_redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign w_halt_now  = bus.halt_req && !bus.resume;

  // The ROM is only read on a cycle whose word will actually be captured.
  assign bus.rom_en     = (r_state == S_FETCH) && !bus.stall && !bus.redirect_valid && w_in_range;
  assign bus.rom_addr   = r_pc;
  assign bus.id_instr   = r_id_instr;
  assign bus.id_pc      = r_id_pc;
  assign bus.id_valid   = r_id_valid;
  assign bus.fault      = r_fault;
  assign bus.fault_addr = r_fault_addr;
  assign bus.fetch_cnt  = r_fetch_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
      r_id_valid   <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fetch_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;

        S_FETCH: begin
          if (w_redir_bad) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_addr <= bus.redirect_pc;
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
          end else if (w_redir_ok) begin
            // Flush wins over stall; a concurrent halt still takes effect.
            r_pc       <= bus.redirect_pc;
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            if (w_halt_now) r_state <= S_HALT;
          end else if (!w_in_range) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_addr <= r_pc;
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
          end else begin
            if (!bus.stall) begin
              r_id_instr  <= bus.rom_instr;
              r_id_pc     <= r_pc;
              r_id_valid  <= 1'b1;
              r_pc        <= r_pc + 32'd4;
              r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_halt_now) r_state <= S_HALT;
          end
        end

        S_HALT: begin
          if (w_redir_bad) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_addr <= bus.redirect_pc;
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
          end else begin
            if (w_redir_ok) begin
              r_pc       <= bus.redirect_pc;
              r_id_valid <= 1'b0;
              r_id_instr <= '0;
            end else if (!bus.stall) begin
              r_id_valid <= 1'b0;
            end
            if (bus.resume) r_state <= S_FETCH;
          end
        end

        S_FAULT: r_id_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer in front of the combinational instruction ROM (32-bit big-endian words, byte address, 1 KiB by default). It holds the PC and drives the ROM enable and address. It captures each returned word into the IF/ID register with a valid flag, and handles stall, redirect (branch/jump), halt/resume, and fault on misaligned or out-of-range addresses. It sits between the ROM and the decode stage; redirect, stall and halt come from later pipeline stages.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
MEM_BYTES, 1024, ROM size in bytes; valid addresses are 0 to MEM_BYTES-1.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous active-high reset.
stall  input  1  decode not ready; hold the IF/ID register and the PC.
redirect_valid  input  1  load a new PC this cycle.
redirect_pc  input  32  redirect target byte address.
halt_req  input  1  stop fetching after this edge.
resume  input  1  leave HALT.
rom_en  output  1  ROM enable; ROM outputs 0 (NOP) when low.
rom_addr  output  32  ROM byte address.
rom_instr  input  32  ROM data, valid in the same cycle (combinational).
id_instr  output  32  IF/ID instruction.
id_pc  output  32  address of id_instr.
id_valid  output  1  id_instr is a real fetched instruction.
fault  output  1  sticky fetch fault.
fault_addr  output  32  offending address.
fetch_cnt  output  32  count of instructions delivered.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pc=RESET_PC.
  - id_instr=0, id_pc=0, id_valid=0.
  - fault=0, fault_addr=0, fetch_cnt=0.
- States:
  - IDLE: first cycle after rst deasserts. No fetch. Always goes to FETCH next.
  - FETCH: normal fetching.
  - HALT: fetching stopped by halt_req.
  - FAULT: terminal; left only by reset.
- Outputs:
  - rom_addr = pc in every state.
  - rom_en = 1 only when state=FETCH, stall=0, redirect_valid=0 and the PC is in range (pc < MEM_BYTES).
- FETCH, per edge, in this priority order:
  1. redirect_valid=1, aligned target (redirect_pc[1:0]==0): pc<=redirect_pc; id_valid<=0; id_instr<=0. Stall is ignored because a flush overrides it. fetch_cnt is unchanged.
  2. redirect_valid=1, misaligned target: state<=FAULT; fault<=1; fault_addr<=redirect_pc; id_valid<=0; id_instr<=0.
  3. pc >= MEM_BYTES: state<=FAULT; fault<=1; fault_addr<=pc; id_valid<=0; id_instr<=0.
  4. stall=1: PC and all id_* registers hold.
  5. Otherwise: id_instr<=rom_instr; id_pc<=pc; id_valid<=1; pc<=pc+4 (modulo 2^32); fetch_cnt<=fetch_cnt+1 (wraps).
- halt_req=1 in FETCH, with no redirect or fault that edge:
  - The fetch in step 5 still completes if not stalled.
  - Then state<=HALT.
- HALT:
  - On entry edge: the instruction from the final fetch stays in id_instr with id_valid=1. On the next edge id_valid<=0 unless stall=1, in which case it holds until stall drops.
  - An aligned redirect updates pc and stays in HALT; a misaligned redirect goes to FAULT.
  - resume=1 returns to FETCH next edge with pc unchanged; resume has priority over halt_req in the same cycle.
- FAULT:
  - rom_en=0, id_valid=0.
  - pc, fault and fault_addr hold; all inputs are ignored.
- Simultaneous redirect and halt_req in FETCH: the redirect is applied and state<=HALT.
- Latency: the instruction at address A appears on id_instr one edge after rom_addr=A is presented unstalled.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 0. With the default MEM_BYTES this address is out of range, so it faults before it is ever fetched.

Test Plan:
1. Reset then run, no stall; ROM words 0x11111111, 0x22222222, 0x33333333 at addresses 0, 4, 8 -> IDLE for one cycle, then id_instr shows those words on successive edges, id_pc = 0, 4, 8, id_valid=1, fetch_cnt=3.
2. stall held 3 cycles while id_pc=4 -> id_instr, id_pc and pc hold, rom_en=0, fetch_cnt constant; fetch resumes at 8 after stall drops.
3. redirect_valid with redirect_pc=0x40 together with stall=1 -> next edge id_valid=0 and id_instr=0; following edge id_pc=0x40 with the word at 0x40.
4. redirect_pc=0x42 -> fault=1, fault_addr=0x42, state FAULT, rom_en=0; remains stuck until rst, and rst mid-fault clears everything to reset values asynchronously.
5. Sequential fetch reaching pc=0x400 (MEM_BYTES=1024) -> the last delivered instruction has id_pc=0x3FC, then fault=1 with fault_addr=0x400.
6. halt_req at id_pc=8; resume pulsed 4 cycles later -> id_valid=0 during HALT; the first instruction after resume has id_pc=0xC; halt_req together with resume keeps fetching.
